seg7_scan_driver: RTL and testbench

Parametrised successor to the two-digit 0-59 seven-segment decoder. It accepts a binary value over a valid/ready handshake and converts it sequentially to BCD (shift-add-3). It then drives NUM_DIGITS common-cathode/anode digits through one time-multiplexed segment bus, with leading-zero blanking and overflow indication. It sits between the clock counters (seconds/minutes/hours) and the board display pins.

---
 rtl/seg7_pkg.sv | 23 ++
 rtl/bin2bcd_seq.sv | 97 +++++++++
 rtl/seg7_scan_driver.sv | 104 ++++++++++
 tb/tb_seg7_scan_driver.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared types, segment encodings and FSM states for the scan driver
package seg7_pkg;

  typedef logic [6:0] seg_t;

  typedef enum logic [1:0] {IDLE, CONV, LOAD} state_t;

  // Active-high {a,b,c,d,e,f,g}; bit6 = a, bit0 = g.
  localparam seg_t SEG_BLANK = 7'b0000000;
  localparam seg_t SEG_DASH  = 7'b0000001;

  localparam seg_t SEG_DIGITS [0:9] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
    7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011
  };

  function automatic seg_t seg7_encode(input logic [3:0] bcd);
    if (bcd > 4'd9)
      return SEG_BLANK;
    return SEG_DIGITS[bcd];
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// rtl/bin2bcd_seq.sv - handshake FSM and sequential shift-add-3 binary to BCD converter
module bin2bcd_seq
  import seg7_pkg::*;
#(
  parameter int IN_W       = 6,
  parameter int NUM_DIGITS = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [IN_W-1:0]         in_value,
  output logic                    busy,
  output logic [4*NUM_DIGITS-1:0] bcd,
  output logic                    ovf,
  output logic                    done
);

  localparam int BW = 4 * NUM_DIGITS;
  localparam int CW = $clog2(IN_W + 1);

  state_t          state, state_nx;
  logic [IN_W-1:0] sh;
  logic [BW-1:0]   work;
  logic [BW-1:0]   adj;
  logic            ovf_w;
  logic [CW-1:0]   cnt;

  always_comb begin
    adj = work;
    for (int d = 0; d < NUM_DIGITS; d++) begin
      if (work[4*d +: 4] >= 4'd5)
        adj[4*d +: 4] = work[4*d +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (in_valid) state_nx = CONV;
      CONV:    if (cnt == CW'(IN_W - 1)) state_nx = LOAD;
      LOAD:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    in_ready = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      IDLE:    in_ready = 1'b1;
      CONV:    busy     = 1'b1;
      LOAD:    begin busy = 1'b1; done = 1'b1; end
      default: in_ready = 1'b1;
    endcase
  end

  // The top bit of the adjusted top digit is what gets shifted out; once lost the value is out of range.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh    <= '0;
      work  <= '0;
      ovf_w <= 1'b0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            sh    <= in_value;
            work  <= '0;
            ovf_w <= 1'b0;
            cnt   <= '0;
          end
        end
        CONV: begin
          work  <= {adj[BW-2:0], sh[IN_W-1]};
          ovf_w <= ovf_w | adj[BW-1];
          sh    <= sh << 1;
          cnt   <= cnt + CW'(1);
        end
        default: ;
      endcase
    end
  end

  assign bcd = work;
  assign ovf = ovf_w;

endmodule

// File: rtl/seg7_scan_driver.sv
// rtl/seg7_scan_driver.sv - value-to-display top: display registers, digit scan, blanking, polarity
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int IN_W           = 6,
  parameter int NUM_DIGITS     = 2,
  parameter int SCAN_DIV       = 50000,
  parameter int SEG_ACTIVE_LOW = 0,
  parameter int AN_ACTIVE_LOW  = 0,
  parameter int BLANK_LZ       = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [IN_W-1:0]       in_value,
  output logic [6:0]            seg,
  output logic [NUM_DIGITS-1:0] an,
  output logic                  busy,
  output logic                  ovf
);

  localparam int BW = 4 * NUM_DIGITS;
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic [BW-1:0]         conv_bcd;
  logic                  conv_ovf;
  logic                  conv_done;
  logic [BW-1:0]         disp_bcd;
  logic                  disp_ovf;
  logic [SW-1:0]         scan_cnt;
  logic                  tick;
  logic [IW-1:0]         idx, idx_nx;
  logic [NUM_DIGITS-1:0] nz_above;
  logic [3:0]            digit;
  seg_t                  seg_r, seg_nx;
  logic [NUM_DIGITS-1:0] an_r, an_nx;

  bin2bcd_seq #(
    .IN_W       (IN_W),
    .NUM_DIGITS (NUM_DIGITS)
  ) u_conv (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_value (in_value),
    .busy     (busy),
    .bcd      (conv_bcd),
    .ovf      (conv_ovf),
    .done     (conv_done)
  );

  assign tick   = (scan_cnt == SW'(SCAN_DIV - 1));
  assign idx_nx = (idx == IW'(NUM_DIGITS - 1)) ? '0 : idx + IW'(1);

  // nz_above[k]: digit k or some higher digit is non-zero, so digit k must be shown.
  always_comb begin
    nz_above = '0;
    nz_above[NUM_DIGITS-1] = |disp_bcd[BW-1 -: 4];
    for (int k = NUM_DIGITS - 2; k >= 0; k--)
      nz_above[k] = nz_above[k+1] | (|disp_bcd[4*k +: 4]);
  end

  always_comb begin
    digit = disp_bcd[{idx_nx, 2'b00} +: 4];
    an_nx = '0;
    an_nx[idx_nx] = 1'b1;
    if (disp_ovf)
      seg_nx = SEG_DASH;
    else if ((BLANK_LZ != 0) && (idx_nx != '0) && !nz_above[idx_nx])
      seg_nx = SEG_BLANK;
    else
      seg_nx = seg7_encode(digit);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      disp_bcd <= '0;
      disp_ovf <= 1'b0;
      scan_cnt <= '0;
      idx      <= IW'(NUM_DIGITS - 1);
      seg_r    <= SEG_BLANK;
      an_r     <= '0;
    end else begin
      if (conv_done) begin
        disp_bcd <= conv_bcd;
        disp_ovf <= conv_ovf;
      end
      scan_cnt <= tick ? '0 : scan_cnt + SW'(1);
      if (tick) begin
        idx   <= idx_nx;
        seg_r <= seg_nx;
        an_r  <= an_nx;
      end
    end
  end

  assign seg = (SEG_ACTIVE_LOW != 0) ? ~seg_r : seg_r;
  assign an  = (AN_ACTIVE_LOW != 0) ? ~an_r : an_r;
  assign ovf = disp_ovf;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb/tb_seg7_scan_driver.sv - scoreboard bench for seg7_scan_driver, both output polarities
module tb_seg7_scan_driver;

  localparam int IN_W = 6;
  localparam int ND   = 2;
  localparam int S    = 4;

  logic            clk      = 1'b0;
  logic            rst_n    = 1'b0;
  logic            in_valid = 1'b0;
  logic [IN_W-1:0] in_value = '0;

  logic            in_ready, busy, ovf;
  logic [6:0]      seg;
  logic [ND-1:0]   an;
  logic            in_ready_i, busy_i, ovf_i;
  logic [6:0]      seg_i;
  logic [ND-1:0]   an_i;

  seg7_scan_driver #(
    .IN_W(IN_W), .NUM_DIGITS(ND), .SCAN_DIV(S),
    .SEG_ACTIVE_LOW(0), .AN_ACTIVE_LOW(0), .BLANK_LZ(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_value(in_value), .seg(seg), .an(an), .busy(busy), .ovf(ovf)
  );

  seg7_scan_driver #(
    .IN_W(IN_W), .NUM_DIGITS(ND), .SCAN_DIV(S),
    .SEG_ACTIVE_LOW(1), .AN_ACTIVE_LOW(1), .BLANK_LZ(1)
  ) dut_inv (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_i),
    .in_value(in_value), .seg(seg_i), .an(an_i), .busy(busy_i), .ovf(ovf_i)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [6:0]    seg;
    logic [ND-1:0] dig;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   e;
  int   model_val = 0;
  logic [ND-1:0] prev_an = '0;
  logic [6:0] enc [0:9] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
    7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011
  };

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) e <= 0;
    else        e <= e + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] exp_seg(input int v, input int k);
    int p = 1;
    for (int i = 0; i < k; i++) p = p * 10;
    if (v > 99) return 7'b0000001;
    if (k > 0 && v < p) return 7'b0000000;
    return enc[(v / p) % 10];
  endfunction

  // Monitor: every new digit enable is one presented output.
  always @(negedge clk) begin
    exp_t x;
    logic [6:0] seg_inv;
    logic [ND-1:0] dig_inv;
    if (an !== prev_an && q.size() > 0) begin
      x = q.pop_front();
      seg_inv = ~x.seg;
      dig_inv = ~x.dig;
      chk("seg", seg, x.seg);
      chk("an", an, x.dig);
      chk("seg_inv", seg_i, seg_inv);
      chk("an_inv", an_i, dig_inv);
    end
    prev_an <= an;
  end

  task automatic wait_ready();
    int c = 0;
    while (in_ready !== 1'b1 && c < 50) begin
      @(negedge clk);
      c++;
    end
    chk("ready_timeout", c < 50, 1);
  endtask

  task automatic send(input int v);
    int n = 0;
    in_value = IN_W'(v);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    while (in_ready === 1'b0 && n < 50) begin
      chk("busy", busy, 1);
      n++;
      @(negedge clk);
    end
    chk("busy_len", n, IN_W + 1);
    model_val = v;
    chk("ovf", ovf, (v > 99) ? 1 : 0);
  endtask

  // Queue one full scan round, aligned so the next clock edge is a scan tick.
  task automatic show();
    int c = 0;
    int k;
    while ((e + 1) % S != 0 && c < 2 * S) begin
      @(negedge clk);
      c++;
    end
    k = (e + 1) / S;
    for (int j = 0; j < ND; j++) begin
      int d;
      exp_t x;
      d = (k - 1 + j) % ND;
      x.seg = exp_seg(model_val, d);
      x.dig = ND'(1 << d);
      q.push_back(x);
    end
    c = 0;
    while (q.size() > 0 && c < ND * S + 4) begin
      @(negedge clk);
      c++;
    end
    chk("scan_timeout", q.size(), 0);
    q.delete();
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_ready", in_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_seg", seg, 7'b0000000);
    chk("rst_an", an, 2'b00);
    chk("rst_seg_inv", seg_i, 7'b1111111);
    chk("rst_an_inv", an_i, 2'b11);
    rst_n = 1'b1;
    for (int i = 1; i < S; i++) begin
      @(negedge clk);
      chk("pre_scan_an", an, 2'b00);
      chk("pre_scan_seg", seg, 7'b0000000);
    end
    model_val = 0;
    show();

    send(47); show();
    send(5);  show();
    send(59); show();
    send(63); show();
    send(10); show();

    in_value = IN_W'(33);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    in_value = IN_W'(22);
    in_valid = 1'b1;
    @(negedge clk);
    chk("busy_ignore_ready", in_ready, 0);
    in_valid = 1'b0;
    wait_ready();
    model_val = 33;
    show();

    in_value = IN_W'(12);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_ready", in_ready, 1);
    chk("midrst_busy", busy, 0);
    chk("midrst_ovf", ovf, 0);
    chk("midrst_seg", seg, 7'b0000000);
    chk("midrst_an", an, 2'b00);
    @(negedge clk);
    rst_n = 1'b1;
    model_val = 0;
    show();

    repeat (20) begin
      send(int'($urandom_range(0, 63)));
      show();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
